sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- SIZE, default 16, number of words.
- DATA_WIDTH, default 32, word width.
- ADDR_WIDTH, default 4, address width.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- p0_req_valid  in  1  port 0 request present.
- p0_req_ready  out  1  port 0 request accepted this cycle.
- p0_req_we  in  1  port 0 request type: 1 = write, 0 = read.
- p0_req_addr  in  ADDR_WIDTH  port 0 word address.
- p0_req_wdata  in  DATA_WIDTH  port 0 write data.
- p0_resp_valid  out  1  port 0 response pulse.
- p0_resp_rdata  out  DATA_WIDTH  port 0 read data, meaningful only when p0_resp_valid=1 for a read.
- p1_*  same set as p0_*, for port 1.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-004 Transitions SHALL be IDLE->ACCESS on accept, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-005 In IDLE, the winning port SHALL see its pN_req_ready=1 combinationally from its pN_req_valid; the losing port SHALL see ready=0.
REQ-006 pN_req_ready SHALL be 0 in ACCESS and RESP.
REQ-007 A request is accepted when valid&&ready at a clock edge; the edge SHALL capture owner, we, addr and wdata into registers.
REQ-008 Arbitration SHALL be round-robin:
- If exactly one port is valid, that port wins.
- If both are valid, the port not recorded in last_grant wins.
- last_grant updates on every accept.
REQ-009 In ACCESS, the block SHALL drive the SRAM instance with the registered addr/wdata: we=1 for a write, or re=1 for a read; exactly one of we/re is 1.
REQ-010 In every state other than ACCESS, SRAM we and re SHALL be 0.
REQ-011 The SRAM SHALL present read data on the clock after re; in RESP, the owner's resp_rdata SHALL equal the SRAM data_out.
REQ-012 In RESP, the owner's pN_resp_valid SHALL be 1 for exactly one cycle, for both reads and writes (a write acknowledge).
REQ-013 The non-owner's resp_valid SHALL be 0 throughout.
REQ-014 Latency SHALL be fixed: accept at edge T, SRAM access during cycle T+1, resp_valid during cycle T+2.
REQ-015 Peak throughput SHALL be one transaction per 3 cycles; the next accept may occur at the edge ending the RESP cycle's successor IDLE cycle.
REQ-016 A request deasserted before acceptance SHALL be dropped with no side effects.
REQ-017 Requesters SHALL hold valid and payload stable until accepted; the block does not check this.
REQ-018 A write followed by a read of the same address SHALL return the written data, because accesses are strictly serialized.
REQ-019 Address wrap SHALL NOT occur: the full ADDR_WIDTH range is valid when SIZE = 2^ADDR_WIDTH; addresses >= SIZE are outside contract.
REQ-020 pN_resp_rdata SHALL be 0 whenever pN_resp_valid=0.

Reset
REQ-021 While rst=1, the block SHALL force: state=IDLE, last_grant=1 (so port 0 wins the first tie), and captured registers to 0.
REQ-022 While rst=1, all ready and resp_valid outputs SHALL be 0, resp_rdata SHALL be 0, and SRAM we/re SHALL be 0.
REQ-023 Reset asserted mid-transaction SHALL abort it with no response pulse; a write aborted in ACCESS may or may not have reached memory.
REQ-024 SRAM contents SHALL NOT be cleared by reset.
REQ-025 On the first edge after rst deasserts, the block SHALL be able to accept a request.

Structure
REQ-026 A shared package sram_arb_pkg SHALL hold:
- the state enum (IDLE, ACCESS, RESP);
- the constant NUM_PORTS=2.
REQ-027 The block SHALL contain exactly one sub-module: an instance of sram, with SIZE/DATA_WIDTH/ADDR_WIDTH passed through and ports clk, addr, re, we, data_in, data_out.
REQ-028 Port-side state and arbitration logic SHALL be written with two-element arrays indexed by port.

Verification
REQ-029 Single write/read: p0 writes addr 3 = 32'hDEADBEEF, then reads addr 3 -> write ack at T+2; read resp_valid at T'+2 with rdata 32'hDEADBEEF; p1 sees nothing.
REQ-030 Tie after reset: p0 and p1 both valid in the same cycle -> p0 ready first; p1 accepted in the next IDLE; p0 resp precedes p1 resp by 3 cycles.
REQ-031 Sustained contention: both ports hold valid for 6 transactions -> grants alternate p0,p1,p0,p1,p0,p1, with accepts spaced 3 cycles apart.
REQ-032 Cross-port coherence: p1 writes addr 15 = 32'h12345678, then p0 reads addr 15 -> p0 rdata 32'h12345678.
REQ-033 Reset mid-operation: rst asserted during ACCESS of a p0 read -> no p0 resp_valid, state IDLE; a fresh p1 request is accepted on the first edge after reset release.
REQ-034 Full-range sweep: write addr i = {28'h0, i} for i=0..15, then read all -> each returns the matching value; SRAM we/re are never asserted outside ACCESS.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

endpackage

// File: rtl/sram_arbiter_sram.sv
// Single-port synchronous SRAM: write on we, registered read data one clock after re.
module sram #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  re,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [SIZE];

  // Contents deliberately have no reset so data survives an arbiter reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data_in;
    if (re) data_out <= mem[addr];
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter serializing requests onto one SRAM, fixed 3-cycle turnaround.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_resp_valid,
  output logic [DATA_WIDTH-1:0] p0_resp_rdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  output logic                  p1_resp_valid,
  output logic [DATA_WIDTH-1:0] p1_resp_rdata
);

  logic [NUM_PORTS-1:0]  req_valid;
  logic [NUM_PORTS-1:0]  req_ready;
  logic [NUM_PORTS-1:0]  resp_valid;
  logic                  req_we     [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] req_addr   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] req_wdata  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] resp_rdata [NUM_PORTS];

  assign req_valid    = {p1_req_valid, p0_req_valid};
  assign req_we[0]    = p0_req_we;
  assign req_we[1]    = p1_req_we;
  assign req_addr[0]  = p0_req_addr;
  assign req_addr[1]  = p1_req_addr;
  assign req_wdata[0] = p0_req_wdata;
  assign req_wdata[1] = p1_req_wdata;

  assign p0_req_ready  = req_ready[0];
  assign p1_req_ready  = req_ready[1];
  assign p0_resp_valid = resp_valid[0];
  assign p1_resp_valid = resp_valid[1];
  assign p0_resp_rdata = resp_rdata[0];
  assign p1_resp_rdata = resp_rdata[1];

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  winner;
  logic                  sram_we;
  logic                  sram_re;
  logic [DATA_WIDTH-1:0] sram_dout;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    winner = req_valid[1];
    if (&req_valid) winner = ~last_grant_q;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready    = '0;
    unique case (state_q)
      IDLE: begin
        req_ready[winner] = req_valid[winner] & ~rst;
        if (req_ready[winner]) begin
          state_d      = ACCESS;
          owner_d      = winner;
          last_grant_d = winner;
          we_d         = req_we[winner];
          addr_d       = req_addr[winner];
          wdata_d      = req_wdata[winner];
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign sram_we = (state_q == ACCESS) &  we_q;
  assign sram_re = (state_q == ACCESS) & ~we_q;

  // Read data is registered in the SRAM, so it lines up with the RESP cycle.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_resp
    assign resp_valid[i] = (state_q == RESP) && (owner_q == 1'(i));
    assign resp_rdata[i] = resp_valid[i] ? sram_dout : '0;
  end

  sram #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .clk      (clk),
    .addr     (addr_q),
    .re       (sram_re),
    .we       (sram_we),
    .data_in  (wdata_q),
    .data_out (sram_dout)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed requests push expected responses, a monitor checks them.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  valid = '0;
  logic [1:0]  rdy;
  logic [1:0]  resp_v;
  logic        we    [2] = '{1'b0, 1'b0};
  logic [3:0]  addr  [2] = '{4'h0, 4'h0};
  logic [31:0] wdata [2] = '{32'h0, 32'h0};
  logic [31:0] rdata [2];

  typedef struct {
    int          port;
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    int port;
    int cyc;
  } acc_t;

  exp_t sbq[$];
  acc_t acc_log[$];
  int   cyc  = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   viol = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .p0_req_valid  (valid[0]),
    .p0_req_ready  (rdy[0]),
    .p0_req_we     (we[0]),
    .p0_req_addr   (addr[0]),
    .p0_req_wdata  (wdata[0]),
    .p0_resp_valid (resp_v[0]),
    .p0_resp_rdata (rdata[0]),
    .p1_req_valid  (valid[1]),
    .p1_req_ready  (rdy[1]),
    .p1_req_we     (we[1]),
    .p1_req_addr   (addr[1]),
    .p1_req_wdata  (wdata[1]),
    .p1_resp_valid (resp_v[1]),
    .p1_resp_rdata (rdata[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // For reads, d is the expected read data; for writes it is the write data.
  task automatic issue(input int p, input bit w, input logic [3:0] a,
                       input logic [31:0] d, input bit exp_resp);
    int   n;
    exp_t e;
    acc_t ac;
    @(negedge clk);
    valid[p] = 1'b1;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = w ? d : 32'h0;
    n = 0;
    forever begin
      #1;
      if (rdy[p]) break;
      if (n == 60) begin
        chk($sformatf("accept_timeout_p%0d", p), 32'(rdy[p]), 32'h1);
        valid[p] = 1'b0;
        return;
      end
      n++;
      @(negedge clk);
    end
    ac.port = p;
    ac.cyc  = cyc;
    acc_log.push_back(ac);
    if (exp_resp) begin
      e.port = p;
      e.rd   = !w;
      e.data = d;
      e.cyc  = cyc + 2;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    valid[p] = 1'b0;
    we[p]    = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        if (resp_v[p]) begin
          if (sbq.size() == 0) begin
            chk($sformatf("unexpected_resp_p%0d", p), 32'h1, 32'h0);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk($sformatf("resp_port_p%0d", p), 32'(p), 32'(e.port));
            chk($sformatf("resp_cycle_p%0d", p), 32'(cyc), 32'(e.cyc));
            if (e.rd) chk($sformatf("resp_rdata_p%0d", p), rdata[p], e.data);
          end
        end else if (rdata[p] != 32'h0) begin
          viol++;
        end
      end
      if ((dut.sram_we || dut.sram_re) && dut.state_q != ACCESS) viol++;
      if (dut.sram_we && dut.sram_re) viol++;
      if (dut.state_q != IDLE && rdy != 2'b00) viol++;
    end
  end

  initial begin
    int rel;
    // Reset: outputs quiet even with both requests pending.
    valid = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(rdy), 32'h0);
    chk("rst_resp_valid", 32'(resp_v), 32'h0);
    chk("rst_rdata_or", rdata[0] | rdata[1], 32'h0);
    chk("rst_sram_we_re", 32'({dut.sram_we, dut.sram_re}), 32'h0);
    valid = 2'b00;
    @(posedge clk);
    #2 rst = 1'b0;

    // Tie right after reset: p0 first, p1 three cycles later.
    acc_log.delete();
    fork
      issue(0, 1'b1, 4'd1, 32'h11111111, 1'b1);
      issue(1, 1'b1, 4'd2, 32'h22222222, 1'b1);
    join
    chk("tie_first_port", 32'(acc_log[0].port), 32'd0);
    chk("tie_second_port", 32'(acc_log[1].port), 32'd1);
    chk("tie_spacing", 32'(acc_log[1].cyc - acc_log[0].cyc), 32'd3);

    // Single write then read on p0.
    issue(0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b1);
    issue(0, 1'b0, 4'd3, 32'hDEADBEEF, 1'b1);

    // Leave last_grant on p1 so contention starts with p0.
    issue(1, 1'b1, 4'd4, 32'h44444444, 1'b1);
    acc_log.delete();
    fork
      begin : g_c0
        for (int i = 0; i < 3; i++) issue(0, 1'b0, 4'd1, 32'h11111111, 1'b1);
      end
      begin : g_c1
        for (int i = 0; i < 3; i++) issue(1, 1'b0, 4'd2, 32'h22222222, 1'b1);
      end
    join
    chk("contention_count", 32'(acc_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < acc_log.size(); i++) begin
      chk($sformatf("contention_port_%0d", i), 32'(acc_log[i].port), 32'(i % 2));
      if (i > 0)
        chk($sformatf("contention_spacing_%0d", i), 32'(acc_log[i].cyc - acc_log[i-1].cyc), 32'd3);
    end

    // Cross-port coherence.
    issue(1, 1'b1, 4'd15, 32'h12345678, 1'b1);
    issue(0, 1'b0, 4'd15, 32'h12345678, 1'b1);

    // Reset during ACCESS of a p0 read aborts it silently.
    repeat (4) @(negedge clk);
    issue(0, 1'b0, 4'd3, 32'hDEADBEEF, 1'b0);
    chk("abort_in_access", 32'(dut.state_q == ACCESS), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_state_idle", 32'(dut.state_q), 32'(IDLE));
    chk("abort_no_resp_p0", 32'(resp_v[0]), 32'h0);
    @(negedge clk);
    chk("abort_still_no_resp_p0", 32'(resp_v[0]), 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    rel = cyc;
    acc_log.delete();
    issue(1, 1'b1, 4'd5, 32'h55555555, 1'b1);
    chk("post_reset_accept_cycle", 32'(acc_log.size() > 0 ? acc_log[0].cyc : -1), 32'(rel));

    // Full-range sweep.
    for (int i = 0; i < 16; i++) issue(0, 1'b1, 4'(i), 32'(i), 1'b1);
    for (int i = 0; i < 16; i++) issue(i % 2, 1'b0, 4'(i), 32'(i), 1'b1);

    for (int n = 0; n < 20 && sbq.size() != 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    chk("protocol_violations", 32'(viol), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
